// File: rtl/muldiv_hilo_ctrl_if.sv
// muldiv_hilo_ctrl_if: decode-side issue/read bundle for the multiply/divide HI/LO unit
interface muldiv_hilo_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        rd_req;
  logic        rd_sel;
  logic [31:0] rd_data;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, op, a, b, rd_req, rd_sel, input busy, rd_data, stall, hi, lo);
  modport slave  (input start, op, a, b, rd_req, rd_sel, output busy, rd_data, stall, hi, lo);
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: 32-iteration shift-add multiply / restoring divide sequencer owning HI/LO
module muldiv_hilo_ctrl (
  input logic              clk,
  input logic              reset,
  muldiv_hilo_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t      state, state_n;
  logic [4:0]  count;
  logic [63:0] acc, acc_step, prod;
  logic [31:0] opnd, a_raw, hi_q, lo_q, abs_a, abs_b, quo, rem, fix_hi, fix_lo;
  logic        is_div, neg_q, neg_r, div_zero, signed_op, issue;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  always_comb begin
    signed_op = ~bus.op[0];
    issue     = state == IDLE && bus.start;
    abs_a     = (signed_op && bus.a[31]) ? -bus.a : bus.a;
    abs_b     = (signed_op && bus.b[31]) ? -bus.b : bus.b;
    mul_sum   = {1'b0, acc[63:32]} + {1'b0, opnd};
    div_diff  = {1'b0, acc[63:31]} - {2'b0, opnd};
    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    acc_step  = is_div ? (div_diff[33] ? {acc[62:0], 1'b0} : {div_diff[31:0], acc[30:0], 1'b1})
                       : (acc[0] ? {mul_sum, acc[31:1]} : {1'b0, acc[63:1]});
    prod      = neg_q ? -acc : acc;
    quo       = neg_q ? -acc[31:0] : acc[31:0];
    rem       = neg_r ? -acc[63:32] : acc[63:32];
    fix_hi    = !is_div ? prod[63:32] : div_zero ? a_raw : rem;
    fix_lo    = !is_div ? prod[31:0] : div_zero ? 32'hFFFF_FFFF : quo;
  end
  always_comb begin
    state_n = state;
    state_n = (issue && !bus.op[2]) ? RUN :
              (state == RUN && count == 5'd0) ? FIX :
              (state == FIX) ? IDLE : state;
    bus.busy    = state != IDLE;
    bus.stall   = bus.rd_req && state != IDLE;
    bus.rd_data = bus.rd_sel ? hi_q : lo_q;
    bus.hi      = hi_q;
    bus.lo      = lo_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count    <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_raw    <= '0;
      is_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      if (issue && !bus.op[2]) begin
        // both operations share one load: the multiplier/dividend sits in acc, the other operand in opnd
        acc      <= {32'b0, abs_a};
        opnd     <= abs_b;
        count    <= 5'd31;
        a_raw    <= bus.a;
        is_div   <= bus.op[1];
        neg_q    <= signed_op && (bus.a[31] ^ bus.b[31]);
        neg_r    <= signed_op && bus.a[31];
        div_zero <= bus.b == 32'd0;
      end
      if (issue && bus.op == 3'd4) hi_q <= bus.a;
      if (issue && bus.op == 3'd5) lo_q <= bus.a;
      if (state == RUN) begin
        acc   <= acc_step;
        count <= (count == 5'd0) ? 5'd0 : count - 5'd1;
      end
      if (state == FIX) begin
        hi_q <= fix_hi;
        lo_q <= fix_lo;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: directed literal checks plus randomized traffic against an arithmetic HI/LO model
module tb_muldiv_hilo_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  muldiv_hilo_ctrl_if bus();
  muldiv_hilo_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  int m_left = 0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int sx, sy;
    sx = x;
    sy = y;
    if (o == 3'd0) return longint'(sx) * longint'(sy);
    if (o == 3'd1) return {32'b0, x} * {32'b0, y};
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (o == 3'd2) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      return {32'(sx % sy), 32'(sx / sy)};
    end
    return {x % y, x / y};
  endfunction
  // model: a 33-cycle busy countdown; result lands when it expires
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_left <= 0;
      m_hi   <= '0;
      m_lo   <= '0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= p_hi;
        m_lo <= p_lo;
      end
    end else if (bus.start) begin
      if (!bus.op[2]) begin
        {p_hi, p_lo} <= ref_result(bus.op, bus.a, bus.b);
        m_left <= 33;
      end else if (bus.op == 3'd4) m_hi <= bus.a;
      else if (bus.op == 3'd5) m_lo <= bus.a;
    end
  always @(negedge clk) begin
    check("busy", {31'b0, bus.busy}, {31'b0, m_left > 0});
    check("stall", {31'b0, bus.stall}, {31'b0, bus.rd_req && m_left > 0});
    check("rd_data", bus.rd_data, bus.rd_sel ? m_hi : m_lo);
    check("hi", bus.hi, m_hi);
    check("lo", bus.lo, m_lo);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit inject, output int n, output int s);
    step();
    bus.start = 1'b1;
    bus.op = o;
    bus.a = x;
    bus.b = y;
    step();
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    n = 0;
    s = 0;
    if (o < 3'd4) begin
      while (bus.busy && n < 40) begin
        n++;
        if (bus.stall) s++;
        if (inject && n == 5) begin
          bus.start = 1'b1;
          bus.op = 3'd5;
          bus.a = 32'd7;
        end else if (inject && n == 6) bus.start = 1'b0;
        step();
      end
      check("busy timeout", {31'b0, n < 40}, 32'd1);
    end
  endtask
  function automatic logic [31:0] pick();
    case ($urandom % 6)
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction
  initial begin
    int n, s;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    bus.rd_req = 1'b0;
    bus.rd_sel = 1'b0;
    #1 reset = 1'b1;
    repeat (3) step();
    check("reset hi", bus.hi, 32'd0);
    check("reset lo", bus.lo, 32'd0);
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    reset = 1'b0;
    bus.rd_req = 1'b1;
    do_op(3'd1, 32'd5, 32'd4, 1'b0, n, s);
    check("multu 5*4 cycles", n, 33);
    check("multu 5*4 stall cycles", s, 33);
    check("multu 5*4 hi", bus.hi, 32'd0);
    check("multu 5*4 lo", bus.lo, 32'd20);
    check("multu 5*4 rd_data", bus.rd_data, 32'd20);
    check("multu 5*4 stall after", {31'b0, bus.stall}, 32'd0);
    bus.rd_req = 1'b0;
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, n, s);
    check("multu max*2 hi", bus.hi, 32'h1);
    check("multu max*2 lo", bus.lo, 32'hFFFF_FFFE);
    do_op(3'd0, 32'hFFFF_FFFF, 32'd2111222333, 1'b0, n, s);
    check("mult -1*x hi", bus.hi, 32'hFFFF_FFFF);
    check("mult -1*x lo", bus.lo, 32'h8229_4DC3);
    do_op(3'd0, -32'd4, -32'd3, 1'b0, n, s);
    check("mult -4*-3 hi", bus.hi, 32'd0);
    check("mult -4*-3 lo", bus.lo, 32'd12);
    do_op(3'd2, -32'd7, 32'd2, 1'b0, n, s);
    check("div -7/2 lo", bus.lo, 32'hFFFF_FFFD);
    check("div -7/2 hi", bus.hi, 32'hFFFF_FFFF);
    do_op(3'd3, 32'd100, 32'd0, 1'b0, n, s);
    check("divu /0 lo", bus.lo, 32'hFFFF_FFFF);
    check("divu /0 hi", bus.hi, 32'd100);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n, s);
    check("div ovf lo", bus.lo, 32'h8000_0000);
    check("div ovf hi", bus.hi, 32'd0);
    do_op(3'd1, 32'd5, 32'd4, 1'b1, n, s);
    check("start while busy lo", bus.lo, 32'd20);
    do_op(3'd4, 32'h1234, 32'd0, 1'b0, n, s);
    check("mthi hi", bus.hi, 32'h1234);
    check("mthi busy", {31'b0, bus.busy}, 32'd0);
    step();
    bus.start = 1'b1;
    bus.op = 3'd3;
    bus.a = 32'd100;
    bus.b = 32'd7;
    step();
    bus.start = 1'b0;
    repeat (10) step();
    reset = 1'b1;
    #1;
    check("midreset hi", bus.hi, 32'd0);
    check("midreset lo", bus.lo, 32'd0);
    check("midreset busy", {31'b0, bus.busy}, 32'd0);
    step();
    reset = 1'b0;
    do_op(3'd3, 32'd100, 32'd7, 1'b0, n, s);
    check("divu 100/7 cycles", n, 33);
    check("divu 100/7 lo", bus.lo, 32'd14);
    check("divu 100/7 hi", bus.hi, 32'd2);
    repeat (1500) begin
      step();
      bus.start = ($urandom % 3) == 0;
      bus.op = 3'($urandom % 8);
      bus.a = pick();
      bus.b = pick();
      bus.rd_req = 1'($urandom % 2);
      bus.rd_sel = 1'($urandom % 2);
    end
    step();
    bus.start = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo_ctrl.md
# muldiv_hilo_ctrl

Sequencer and owner of the HI/LO register pair for the MIPS multiply/divide path. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decode stage and runs a 32-iteration radix-2 shift-add multiply or restoring divide. It holds the 64-bit result in HI/LO and stalls MFHI/MFLO reads while an operation is in flight. It sits beside the single-cycle ALU and takes over the multi-cycle multiply work.

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  issue strobe, sampled on the rising edge
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 ignored
- a  in  32  multiplicand / dividend / MTHI-MTLO source
- b  in  32  multiplier / divisor
- busy  out  1  multiply or divide in progress
- rd_req  in  1  MFHI/MFLO in decode
- rd_sel  in  1  0 = LO, 1 = HI
- rd_data  out  32  combinational mux of LO/HI per rd_sel
- stall  out  1  combinational, rd_req & busy
- hi, lo  out  32 each  architectural HI/LO, exposed for debug

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start with op MULT..DIVU: latch |a| and |b| (signed ops) or a and b (unsigned ops), record the sign flags, load count = 31, go to RUN.
  - start with MTHI/MTLO: write a to hi or lo at that edge; stay in IDLE.
  - start with op 110/111: no effect.
- RUN, one iteration per cycle:
  - Multiply: 64-bit accumulator; add the shifted multiplicand when the current multiplier bit is 1; shift.
  - Divide: 64-bit {rem, quo} shift-left; trial subtract the divisor; set the quotient bit when the result is non-negative.
  - When count = 0, go to FIX; otherwise decrement count.
- FIX, one cycle, writes hi/lo and returns to IDLE:
  - Signed multiply: negate the 64-bit product when the sign of a differs from the sign of b.
  - Signed divide: negate the quotient when the signs differ; the remainder takes the sign of a.
  - {hi, lo} = product; lo = quotient, hi = remainder.
- Divide by zero (signed and unsigned): lo = 32'hFFFFFFFF, hi = a as issued; no sign fix.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo = 0x80000000, hi = 0.
- start while busy is ignored, including MTHI/MTLO; there is no queue. Decode must gate start on !busy.
- The operand registers are internal, so a and b may change freely after the issue edge.

## Timing
- Reset values: busy = 0, hi = 0, lo = 0, state IDLE, count = 0. stall and rd_data follow from these.
- Multiply/divide latency:
  - Issue edge E0: busy rises after E0.
  - E1..E32: iterations.
  - E33: FIX writes hi/lo and busy falls.
  - busy is high for exactly 33 cycles; new hi/lo values are visible in the cycle after E33.
- The next start may be accepted at the edge after busy falls (E34), so back-to-back issue has a 34-cycle period.
- MTHI/MTLO: 1-cycle latency; the new value is visible on rd_data in the next cycle.
- rd_req in the same cycle as an accepted start: stall = 0 and the old hi/lo is returned.
- rd_req in the cycle after E33: stall = 0 and the new value is returned.
- reset asserted mid-RUN or mid-FIX: abort immediately (asynchronous), hi/lo cleared, busy = 0. No partial result is written.

## Test plan
- MULTU a=5, b=4 -> busy high for 33 cycles, then hi=0, lo=20.
- MULTU a=0xFFFFFFFF, b=2 -> hi=0x00000001, lo=0xFFFFFFFE.
- MULT a=0xFFFFFFFF, b=2111222333 -> hi=0xFFFFFFFF, lo=0x82294DC3.
- MULT a=-4, b=-3 -> hi=0, lo=12.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=100.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Read stall: issue MULTU 5*4, hold rd_req=1 with rd_sel=0 -> stall=1 for all 33 busy cycles, then stall=0 with rd_data=20.
- Start while busy: issue a second start (MTLO a=7) while busy -> ignored; lo=20 at completion.
- MTHI idle: MTHI a=0x1234 while idle -> hi=0x1234 one cycle later, busy stays 0.
- Reset mid-op: reset pulse at iteration 10 of DIVU 100/7 -> hi=lo=0 and busy=0 immediately.
- Post-reset issue: after the mid-op reset, re-issue DIVU 100/7 -> lo=14, hi=2 after 33 cycles.
